// File: rtl/dht11_frame_decoder.sv
// ============================================================================
// Module      : dht11_frame_decoder
// Description : Detects a new stable DHT11 frame, verifies its checksum and
//               converts the integer humidity/temperature bytes to 3-digit BCD
//               with a shift-add-3 engine. Optional DHT11_RANGE_CHK_EN also
//               rejects out-of-range integer readings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dht11_frame_decoder #(
  parameter int STABLE_CYCLES = 16,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [39:0]          frame_in,
  output logic [11:0]          hum_bcd,
  output logic [11:0]          temp_bcd,
  output logic [7:0]           hum_dec,
  output logic [7:0]           temp_dec,
  output logic                 rd_valid,
  output logic                 rd_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_stab_max = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_CONV   = 3'd2,
    S_DONE   = 3'd3,
    S_REJECT = 3'd4
  } state_t;

  state_t           r_state;
  logic [39:0]      r_frame_q;
  logic [39:0]      r_last_acc;
  logic [39:0]      r_work;
  logic [CNT_W-1:0] r_stab_cnt;
  logic [2:0]       r_bit_cnt;
  logic [19:0]      r_hum_sh;
  logic [19:0]      r_temp_sh;

  logic [7:0]       w_sum;
  logic             w_range_bad;
  logic [19:0]      w_hum_next;
  logic [19:0]      w_temp_next;

  // One double-dabble step: {bcd[11:0], bin[7:0]} adjusted then shifted left.
  function automatic logic [19:0] dd_step(input logic [19:0] sh);
    logic [19:0] a;
    a = sh;
    for (int n = 0; n < 3; n++) begin
      if (a[8+4*n +: 4] >= 4'd5)
        a[8+4*n +: 4] = a[8+4*n +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

  assign w_sum       = r_work[39:32] + r_work[31:24] + r_work[23:16] + r_work[15:8];
  assign w_hum_next  = dd_step(r_hum_sh);
  assign w_temp_next = dd_step(r_temp_sh);
  assign busy        = (r_state != S_IDLE);

`ifdef DHT11_RANGE_CHK_EN
  assign w_range_bad = (r_work[39:32] > 8'd99) || (r_work[23:16] > 8'd60);
`else
  assign w_range_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_frame_q  <= '0;
      r_last_acc <= '0;
      r_work     <= '0;
      r_stab_cnt <= '0;
      r_bit_cnt  <= '0;
      r_hum_sh   <= '0;
      r_temp_sh  <= '0;
      hum_bcd    <= '0;
      temp_bcd   <= '0;
      hum_dec    <= '0;
      temp_dec   <= '0;
      rd_valid   <= 1'b0;
      rd_err     <= 1'b0;
      err_cnt    <= '0;
    end else begin
      r_frame_q <= frame_in;
      if (frame_in != r_frame_q)
        r_stab_cnt <= '0;
      else if (r_stab_cnt != c_stab_max)
        r_stab_cnt <= r_stab_cnt + CNT_W'(1);

      rd_valid <= 1'b0;
      rd_err   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // last_acc starts at zero, so the reader's power-up frame is ignored
          if (r_stab_cnt == c_stab_max && r_frame_q != r_last_acc) begin
            r_work     <= r_frame_q;
            r_last_acc <= r_frame_q;
            r_state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_sum != r_work[7:0] || w_range_bad) begin
            rd_err <= 1'b1;
            if (err_cnt != '1)
              err_cnt <= err_cnt + ERR_CNT_W'(1);
            r_state <= S_REJECT;
          end else begin
            r_hum_sh  <= {12'd0, r_work[39:32]};
            r_temp_sh <= {12'd0, r_work[23:16]};
            r_bit_cnt <= '0;
            r_state   <= S_CONV;
          end
        end
        S_CONV: begin
          r_hum_sh  <= w_hum_next;
          r_temp_sh <= w_temp_next;
          r_bit_cnt <= r_bit_cnt + 3'd1;
          // Outputs load with the final step so rd_valid is high during DONE
          if (r_bit_cnt == 3'd7) begin
            hum_bcd  <= w_hum_next[19:8];
            temp_bcd <= w_temp_next[19:8];
            hum_dec  <= r_work[31:24];
            temp_dec <= r_work[15:8];
            rd_valid <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE:   r_state <= S_IDLE;
        S_REJECT: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dht11_frame_decoder.sv
// ============================================================================
// Module      : tb_dht11_frame_decoder
// Description : Self-checking bench for dht11_frame_decoder against a
//               frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dht11_frame_decoder;

  localparam int STABLE = 16;

  logic        clk = 1'b0;
  logic        RST;
  logic [39:0] frame_in;
  logic [11:0] hum_bcd;
  logic [11:0] temp_bcd;
  logic [7:0]  hum_dec;
  logic [7:0]  temp_dec;
  logic        rd_valid;
  logic        rd_err;
  logic [7:0]  err_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [39:0] m_last_acc;
  logic [11:0] m_hum_bcd, m_temp_bcd;
  logic [7:0]  m_hum_dec, m_temp_dec;
  int          m_err;

  dht11_frame_decoder #(.STABLE_CYCLES(STABLE), .ERR_CNT_W(8)) dut (
    .clk      (clk),
    .RST      (RST),
    .frame_in (frame_in),
    .hum_bcd  (hum_bcd),
    .temp_bcd (temp_bcd),
    .hum_dec  (hum_dec),
    .temp_dec (temp_dec),
    .rd_valid (rd_valid),
    .rd_err   (rd_err),
    .err_cnt  (err_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [39:0] mk_frame(input logic [7:0] hi, input logic [7:0] hd,
                                           input logic [7:0] ti, input logic [7:0] td,
                                           input logic bad);
    logic [7:0] s;
    s = 8'((int'(hi) + int'(hd) + int'(ti) + int'(td)) % 256);
    if (bad) s = s ^ 8'h5A;
    return {hi, hd, ti, td, s};
  endfunction

  task automatic reset_model();
    m_last_acc = '0;
    m_hum_bcd  = '0;
    m_temp_bcd = '0;
    m_hum_dec  = '0;
    m_temp_dec = '0;
    m_err      = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_hum_bcd"},  {28'd0, hum_bcd},  {28'd0, m_hum_bcd});
    check({tag, "_temp_bcd"}, {28'd0, temp_bcd}, {28'd0, m_temp_bcd});
    check({tag, "_hum_dec"},  {32'd0, hum_dec},  {32'd0, m_hum_dec});
    check({tag, "_temp_dec"}, {32'd0, temp_dec}, {32'd0, m_temp_dec});
    check({tag, "_err_cnt"},  {32'd0, err_cnt},  40'(m_err));
  endtask

  // Drive a frame at a negedge and hold it; the next posedge is edge 0.
  task automatic present(input string tag, input logic [39:0] f, input int hold);
    int vcnt, ecnt, vcyc, ecyc, both, sum;
    logic accept, good;
    vcnt = 0; ecnt = 0; vcyc = -1; ecyc = -1; both = 0;
    frame_in = f;
    sum  = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
    good = (sum == int'(f[7:0]));
`ifdef DHT11_RANGE_CHK_EN
    if (f[39:32] > 8'd99 || f[23:16] > 8'd60) good = 1'b0;
`endif
    accept = (hold > STABLE) && (f != m_last_acc);
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (rd_valid) begin vcnt++; if (vcyc < 0) vcyc = i; end
      if (rd_err)   begin ecnt++; if (ecyc < 0) ecyc = i; end
      if (rd_valid && rd_err) both++;
    end
    if (accept) begin
      m_last_acc = f;
      if (good) begin
        m_hum_bcd  = to_bcd(int'(f[39:32]));
        m_temp_bcd = to_bcd(int'(f[23:16]));
        m_hum_dec  = f[31:24];
        m_temp_dec = f[15:8];
      end else if (m_err < 255) begin
        m_err++;
      end
    end
    check({tag, "_valid_cnt"}, 40'(vcnt), (accept && good)  ? 40'd1 : 40'd0);
    check({tag, "_err_cnt_pulses"}, 40'(ecnt), (accept && !good) ? 40'd1 : 40'd0);
    if (accept && good)  check({tag, "_valid_lat"}, 40'(vcyc), 40'(STABLE + 10));
    if (accept && !good) check({tag, "_err_lat"},   40'(ecyc), 40'(STABLE + 2));
    check({tag, "_overlap"}, 40'(both), 40'd0);
    check({tag, "_busy_end"}, {39'd0, busy}, 40'd0);
    check_outputs(tag);
  endtask

  initial begin
    logic [39:0] f;
    RST = 1'b1;
    frame_in = '0;
    reset_model();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    check("reset_pulses", {38'd0, rd_valid, rd_err}, 40'd0);
    check("reset_busy", {39'd0, busy}, 40'd0);
    RST = 1'b0;

    // Power-up zero frame is never processed
    present("zero", 40'h0, 40);
    present("good_37", 40'h37_00_1A_00_51, 40);
    present("bad_52", 40'h37_00_1A_00_52, 130);
    present("max_ff", 40'hFF_00_FF_00_FE, 40);

    // Toggling faster than the stability window yields nothing
    for (int k = 0; k < 8; k++)
      present("toggle", k[0] ? 40'h11_02_13_04_2A : 40'h21_00_05_01_27, 5);
    present("after_toggle", 40'h2D_01_14_03_45, 40);

    // Reset abandons an in-flight conversion
    f = 40'h41_00_0C_00_4D;
    frame_in = f;
    repeat (20) @(negedge clk);
    check("mid_conv_busy", {39'd0, busy}, 40'd1);
    RST = 1'b1;
    #1;
    reset_model();
    check_outputs("rst_conv");
    check("rst_conv_pulses", {38'd0, rd_valid, rd_err}, 40'd0);
    @(negedge clk);
    check("rst_conv_hold", {38'd0, rd_valid, rd_err}, 40'd0);
    RST = 1'b0;
    present("re_present", f, 40);

    // Randomized good/bad frames
    for (int k = 0; k < 40; k++) begin
      f = mk_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 9)),
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 9)),
                   ($urandom_range(0, 9) < 3));
      present("rand", f, ($urandom_range(0, 4) == 0) ? 5 : 40);
    end

    // Error counter saturation with distinct bad frames
    for (int k = 0; k < 300; k++) begin
      f = mk_frame(8'($urandom_range(0, 255)), 8'(k),
                   8'($urandom_range(0, 255)), {7'd0, 1'(k >> 8)}, 1'b1);
      present("sat", f, 20);
    end
    check("sat_final", {32'd0, err_cnt}, 40'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/dht11_frame_decoder.md
Name: dht11_frame_decoder

Overview:
- Sits directly downstream of the DHT11 bus reader and consumes its 40-bit frame register, which has no valid strobe.
- Detects each new stable frame and verifies the checksum.
- Converts the integer humidity and temperature bytes to 3-digit BCD with a sequential shift-add-3 engine.
- Presents latched readings plus a one-cycle valid pulse to the reporting/uplink logic; counts bad frames.

Parameters:
- STABLE_CYCLES, 16, consecutive cycles frame_in must hold unchanged before it is accepted (min 2).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock
- RST  in  1  asynchronous active-high reset
- frame_in  in  40  raw reader frame: [39:32] hum_int, [31:24] hum_dec, [23:16] temp_int, [15:8] temp_dec, [7:0] checksum
- hum_bcd  out  12  humidity integer part, BCD hundreds/tens/units
- temp_bcd  out  12  temperature integer part, BCD
- hum_dec  out  8  humidity decimal byte, passed through
- temp_dec  out  8  temperature decimal byte, passed through
- rd_valid  out  1  one-cycle pulse; outputs updated this cycle
- rd_err  out  1  one-cycle pulse; frame rejected
- err_cnt  out  ERR_CNT_W  saturating count of rejected frames
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, RST=1): all outputs 0; state IDLE; frame_q, last_acc, work register, stable counter all 0.
- Input sampling:
  - frame_q <= frame_in every cycle.
  - stab_cnt clears when frame_in != frame_q; otherwise it increments, saturating at STABLE_CYCLES-1.
- FSM:
  - IDLE: when stab_cnt==STABLE_CYCLES-1 and frame_q != last_acc, do work <= frame_q and last_acc <= frame_q, then go to CHECK. Since last_acc resets to 0, an all-zero frame (reader power-up) is never processed.
  - CHECK (1 cycle): compute sum = (work[39:32]+work[31:24]+work[23:16]+work[15:8]) mod 256, 8-bit wrap. If sum != work[7:0], go to REJECT. Otherwise load the BCD shifters with hum_int and temp_int, set the bit counter to 0, and go to CONV.
  - CONV (exactly 8 cycles): each cycle, add 3 to every BCD nibble >=5 of both converters, then shift left 1 pulling the next MSB of the binary byte. Both converters run in parallel. After the 8th cycle go to DONE.
  - DONE (1 cycle): update hum_bcd, temp_bcd, hum_dec, temp_dec; rd_valid=1; go to IDLE.
  - REJECT (1 cycle): rd_err=1; err_cnt increments, saturating at all-ones; outputs hold old values; go to IDLE.
- Latency: CHECK entry to rd_valid is 9 cycles later. CHECK entry to rd_err is 1 cycle later.
- Identical consecutive readings produce no new pulse, because they match last_acc.
- A rejected frame is recorded in last_acc and is not recounted while it stays on the bus.
- frame_in changes while busy: the work register is isolated. The new frame is evaluated on return to IDLE once it is stable.
- rd_valid and rd_err are never high in the same cycle.
- Reset asserted mid-CONV: the conversion is abandoned and every register returns to its reset value. No pulse is generated.
- BCD range: 0..255 maps to 12'h000..12'h255. The hundreds nibble is never >2.

Optional Feature:
- Macro DHT11_RANGE_CHK_EN.
- Defined: CHECK also rejects, going to REJECT, when hum_int > 99 or temp_int > 60, even if the checksum is good.
- Undefined: only the checksum decides; any byte value 0..255 is converted.

Test Plan:
- Frame 40'h3700_1A00_51 held 20 cycles → one rd_valid; hum_bcd=12'h055, temp_bcd=12'h026, hum_dec=0, temp_dec=0; err_cnt=0.
- Frame 40'h3700_1A00_52 (bad checksum) → rd_err one cycle; err_cnt=1; outputs unchanged. Holding the frame another 100 cycles gives no further pulses.
- Frame 40'hFF00_FF00_FE → hum_bcd=12'h255, temp_bcd=12'h255. With DHT11_RANGE_CHK_EN defined, the result is instead rd_err and err_cnt+1.
- frame_in toggling every 5 cycles (STABLE_CYCLES=16) → no pulses. The value held afterwards is accepted exactly 16 cycles after its last change.
- RST pulse during CONV, then the same frame re-presented → all outputs 0 after reset, then a fresh rd_valid with correct BCD.
- 300 bad frames with distinct values → err_cnt saturates at 8'hFF.
